// File: rtl/elevator_seg_scan_if.sv
// Panel-side bundle for elevator_seg_scan: glyph/blank/blink data and
// update strobe from upstream control, plus the scanned display drive back.
interface elevator_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [5*NUM_DIGITS-1:0] glyph_in;
    logic                    update;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    frame_start;

    // Upstream control / testbench side.
    modport master (
        output glyph_in, update, blank_in, blink_in,
        input  an_n, seg_n, frame_start
    );

    // Scanner side.
    modport slave (
        input  glyph_in, update, blank_in, blink_in,
        output an_n, seg_n, frame_start
    );
endinterface

// File: rtl/elevator_seg_scan.sv
// Time-multiplexed 7-segment scanner for the elevator status panel.
// Drives a common-anode display: one digit slot per TICK_CYCLES clocks, a
// one-cycle dead time at the start of each slot, and a shadow/active glyph
// pair so new content is only shown from the next frame boundary.
// Optional feature: define SEG_BLINK_EN to enable per-digit blinking with a
// half-period of BLINK_TICKS digit slots.
module elevator_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_CYCLES = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    elevator_seg_scan_if.slave  bus
);
    localparam int PW = $clog2(TICK_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PRE_MAX  = PW'(TICK_CYCLES - 1);
    localparam logic [IW-1:0]         IDX_MAX  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [PW-1:0] prescaler;
    logic [IW-1:0] index;
    logic          tick;
    logic          wrap;

    logic [NUM_DIGITS-1:0][4:0] shadow_glyph;
    logic [NUM_DIGITS-1:0][4:0] active_glyph;
    logic [NUM_DIGITS-1:0]      shadow_blank;
    logic [NUM_DIGITS-1:0]      active_blank;

    logic                  digit_blinked;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  frame_start_next;

    assign tick = (prescaler == PRE_MAX);
    assign wrap = tick && (index == IDX_MAX);

    // Glyph code to active-low segments {a,b,c,d,e,f,g}.
    function automatic logic [6:0] decode(input logic [4:0] code);
        case (code)
            5'h00:   decode = 7'b0000001;
            5'h01:   decode = 7'b1001111;
            5'h02:   decode = 7'b0010010;
            5'h03:   decode = 7'b0000110;
            5'h04:   decode = 7'b1001100;
            5'h05:   decode = 7'b0100100;
            5'h06:   decode = 7'b0100000;
            5'h07:   decode = 7'b0001111;
            5'h08:   decode = 7'b0000000;
            5'h09:   decode = 7'b0000100;
            5'h0A:   decode = 7'b0110001; // C
            5'h0B:   decode = 7'b0000001; // O
            5'h0C:   decode = 7'b0111111; // up-bar
            5'h0D:   decode = 7'b1110111; // down-bar
            5'h0E:   decode = 7'b1111110; // idle-bar
            5'h0F:   decode = 7'b0011101; // call-up
            5'h10:   decode = 7'b1100011; // call-down
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Slot timebase: prescaler wraps every TICK_CYCLES, index steps on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                index <= (index == IDX_MAX) ? '0 : index + 1'b1;
            end
        end
    end

    // Shadow capture on update; shadow-to-active copy at each frame wrap.
    // NOTE: these registers are reset (unlike a RAM) because the first frame
    // after reset must be blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_glyph <= {NUM_DIGITS{5'h1F}};
            active_glyph <= {NUM_DIGITS{5'h1F}};
            shadow_blank <= '0;
            active_blank <= '0;
        end else begin
            if (bus.update) begin
                shadow_glyph <= bus.glyph_in;
                shadow_blank <= bus.blank_in;
            end
            // NOTE: non-blocking assignment makes the swap copy the pre-edge
            // shadow, so an update on the swapping edge shows a frame later.
            if (wrap) begin
                active_glyph <= shadow_glyph;
                active_blank <= shadow_blank;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Blink half-period counter in digit slots; phase flips on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BLINK_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign digit_blinked = blink_phase & bus.blink_in[index];
`else
    // Blinking is compiled out; blink_in is intentionally ignored.
    logic unused_blink;
    assign unused_blink  = ^bus.blink_in;
    assign digit_blinked = 1'b0;
`endif

    // Next-output selection: dead time on slot's first cycle, else lit digit.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        an_next          = '1;
        seg_next         = 7'b1111111;
        frame_start_next = (prescaler == '0) && (index == '0);
        if (prescaler != '0) begin
            an_next = ~(ONE_HOT0 << index);
            if (!active_blank[index] && !digit_blinked) begin
                seg_next = decode(active_glyph[index]);
            end
        end
    end

    // Registered display drive, one cycle behind prescaler/index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.an_n        <= '1;
            bus.seg_n       <= 7'b1111111;
            bus.frame_start <= 1'b0;
        end else begin
            bus.an_n        <= an_next;
            bus.seg_n       <= seg_next;
            bus.frame_start <= frame_start_next;
        end
    end
endmodule
